// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer: borrows the shared ALU for one
// shift-add / shift-subtract iteration per cycle and produces MIPS-style HI/LO.
module mdu_sequencer #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic          op_r;
    logic [31:0]   acc_hi;   // PH (multiply) or R (divide)
    logic [31:0]   acc_lo;   // PL (multiply) or Q (divide)
    logic [31:0]   opnd;     // M (multiply) or D (divide)
    logic [31:0]   mul_sum, iter_hi, iter_lo;
    logic          mul_carry, div_ge, accept, zero_div;

    logic unused_inputs;
    assign unused_inputs = alu_zero;

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = (state == IDLE) && start;
    assign zero_div = op && (rt_val == 32'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        if (state == RUN) begin
            alu_b = opnd;
            if (op_r) begin
                alu_a       = {acc_hi[30:0], acc_lo[31]};
                alu_control = ALU_SUB;
            end else begin
                alu_a = acc_hi;
            end
        end
    end

    // The ALU's add carry-out is lost at 32 bits; recover it by the wrap-around compare.
    always_comb begin
        mul_sum   = acc_lo[0] ? alu_result : acc_hi;
        mul_carry = acc_lo[0] & (alu_result < acc_hi);
        div_ge    = acc_hi[31] | (alu_a >= opnd);
        if (op_r) begin
            iter_hi = div_ge ? alu_result : alu_a;
            iter_lo = {acc_lo[30:0], div_ge};
        end else begin
            iter_hi = {mul_carry, mul_sum[31:1]};
            iter_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = zero_div ? DONE : RUN;
            RUN:  if (count == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            op_r        <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_r   <= op;
                count  <= '0;
                acc_hi <= '0;
                acc_lo <= op ? rs_val : rt_val;
                opnd   <= op ? rt_val : rs_val;
                if (zero_div) begin
                    hi          <= rs_val;
                    lo          <= 32'hFFFF_FFFF;
                    div_by_zero <= 1'b1;
                end else begin
                    div_by_zero <= 1'b0;
                end
            end else if (state == RUN) begin
                acc_hi <= iter_hi;
                acc_lo <= iter_lo;
                count  <= count + 1'b1;
                if (count == LAST) begin
                    hi <= iter_hi;
                    lo <= iter_lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: ideal ALU model, directed cases,
// randomized operations against a plain-arithmetic reference.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_by_zero, alu_zero;
    logic [31:0] hi, lo, alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;

    int total = 0;
    int bad = 0;
    int done_count = 0;

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Ideal shared ALU as seen by the sequencer.
    assign alu_result = (alu_control == 3'b110) ? alu_a - alu_b : alu_a + alu_b;
    assign alu_zero   = (alu_result == 32'd0);

    always @(posedge clk) if (done) done_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] prod;
        if (o) begin
            if (b == 32'd0) begin
                eh = a;
                el = 32'hFFFF_FFFF;
            end else begin
                eh = a % b;
                el = a / b;
            end
        end else begin
            prod = 64'(a) * 64'(b);
            eh   = prod[63:32];
            el   = prod[31:0];
        end
    endtask

    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit mid);
        logic [31:0] eh, el;
        int cycles, dc0;
        bit dz;
        dz = o && (b == 32'd0);
        model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        dc0 = done_count;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; rs_val = $urandom; rt_val = $urandom;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                check("busy_rise", 32'(busy), 32'd1);
                check("alu_ctl", 32'(alu_control), (o && !dz) ? 32'd6 : 32'd2);
            end
            if (mid && cycles == 10) begin
                start = 1'b1; op = 1'b1; rs_val = 32'd1000; rt_val = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (!done && cycles < 40) check("busy_run", 32'(busy), 32'd1);
        end while (!done && cycles < 40);
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(cycles), dz ? 32'd1 : 32'd33);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("div_by_zero", 32'(div_by_zero), 32'(dz));
        check("busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_drop", 32'(done), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
        check("hi_hold", hi, eh);
        check("lo_hold", lo, el);
        check("done_pulses", 32'(done_count - dc0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic o;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; op = 1'b0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("idle_alu_a", alu_a, 32'd0);
        check("idle_alu_b", alu_b, 32'd0);
        check("idle_alu_ctl", 32'(alu_control), 32'd2);
        reset = 1'b0;

        do_op(1'b0, 32'd7, 32'd6, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b1, 32'd100, 32'd7, 1'b0);
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(1'b1, 32'd5, 32'd9, 1'b0);
        do_op(1'b0, 32'd7, 32'd6, 1'b1);

        for (int i = 0; i < 10; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            do_op(o, a, b, 1'b0);
        end

        do_op(1'b1, 32'd123, 32'd0, 1'b0);
        do_op(1'b0, 32'd2, 32'd3, 1'b0);

        // Asynchronous reset in the middle of a multiply, away from any clock edge.
        @(negedge clk);
        start = 1'b1; op = 1'b0; rs_val = 32'd7; rt_val = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        dc = done_count;
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_alu_a", alu_a, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("arst_no_done", 32'(done_count - dc), 32'd0);
        do_op(1'b0, 32'd3, 32'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
